// File: rtl/bcd_updown_counter.sv
// Synchronous multi-digit BCD up/down counter with clear, load, terminal count and wrap pulse.
// Define BCD_CNT_SATURATE_EN to saturate at all-9 / all-0 instead of wrapping.
module bcd_updown_counter #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   q,
  output logic                  tc,
  output logic                  wrap,
  output logic                  err
);
  localparam int W = 4*DIGITS;

  logic [W-1:0]      q_reg, q_next;
  logic [W-1:0]      q_up, q_dn, q_ld;
  logic              wrap_reg, wrap_next;
  logic              err_reg, err_next;
  logic [DIGITS:0]   nine_chain, zero_chain;
  logic [DIGITS-1:0] bad_digit;
  logic              all_nine, all_zero;

  assign nine_chain[0] = 1'b1;
  assign zero_chain[0] = 1'b1;

  // Each digit steps only when every lower digit sits at its carry/borrow value.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] d, ld;
      assign d  = q_reg[4*gi +: 4];
      assign ld = load_val[4*gi +: 4];
      assign nine_chain[gi+1] = nine_chain[gi] & (d == 4'd9);
      assign zero_chain[gi+1] = zero_chain[gi] & (d == 4'd0);
      assign q_up[4*gi +: 4]  = !nine_chain[gi] ? d : ((d == 4'd9) ? 4'd0 : d + 4'd1);
      assign q_dn[4*gi +: 4]  = !zero_chain[gi] ? d : ((d == 4'd0) ? 4'd9 : d - 4'd1);
      assign bad_digit[gi]    = (ld > 4'd9);
      assign q_ld[4*gi +: 4]  = bad_digit[gi] ? 4'd0 : ld;
    end
  endgenerate

  assign all_nine = nine_chain[DIGITS];
  assign all_zero = zero_chain[DIGITS];

  always_comb begin
    q_next    = q_reg;
    wrap_next = 1'b0;
    err_next  = err_reg;
    if (clr) begin
      q_next = '0;
    end else if (load) begin
      q_next = q_ld;
      if (|bad_digit) err_next = 1'b1;
    end else if (en) begin
      if (up) begin
`ifdef BCD_CNT_SATURATE_EN
        if (!all_nine) q_next = q_up;
`else
        q_next    = q_up;
        wrap_next = all_nine;
`endif
      end else begin
`ifdef BCD_CNT_SATURATE_EN
        if (!all_zero) q_next = q_dn;
`else
        q_next    = q_dn;
        wrap_next = all_zero;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      q_reg    <= '0;
      wrap_reg <= 1'b0;
      err_reg  <= 1'b0;
    end else begin
      q_reg    <= q_next;
      wrap_reg <= wrap_next;
      err_reg  <= err_next;
    end
  end

  assign q    = q_reg;
  assign wrap = wrap_reg;
  assign err  = err_reg;
  // Left ungated by clr/load so it can drive the next stage's enable directly.
  assign tc   = en & (up ? all_nine : all_zero);
endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench for bcd_updown_counter: 2- and 3-digit instances plus a two-stage cascade.
module tb_bcd_updown_counter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DIGITS=2 instance
  logic en2, up2, clr2, load2;
  logic [7:0] lv2, q2;
  logic tc2, wrap2, err2;
  // DIGITS=3 instance
  logic en3, up3, clr3, load3;
  logic [11:0] lv3, q3;
  logic tc3, wrap3, err3;
  // cascade
  logic cen;
  logic [7:0] q_lo, q_hi;
  logic tc_lo, tc_hi, wrap_lo, wrap_hi, err_lo, err_hi;
  logic tie0;
  logic [7:0] tie_val;

  int checks = 0;
  int failures = 0;

  bcd_updown_counter #(.DIGITS(2)) u2 (
    .clk(clk), .rst(rst), .en(en2), .up(up2), .clr(clr2), .load(load2),
    .load_val(lv2), .q(q2), .tc(tc2), .wrap(wrap2), .err(err2));

  bcd_updown_counter #(.DIGITS(3)) u3 (
    .clk(clk), .rst(rst), .en(en3), .up(up3), .clr(clr3), .load(load3),
    .load_val(lv3), .q(q3), .tc(tc3), .wrap(wrap3), .err(err3));

  bcd_updown_counter #(.DIGITS(2)) u_lo (
    .clk(clk), .rst(rst), .en(cen), .up(1'b1), .clr(tie0), .load(tie0),
    .load_val(tie_val), .q(q_lo), .tc(tc_lo), .wrap(wrap_lo), .err(err_lo));

  bcd_updown_counter #(.DIGITS(2)) u_hi (
    .clk(clk), .rst(rst), .en(tc_lo), .up(1'b1), .clr(tie0), .load(tie0),
    .load_val(tie_val), .q(q_hi), .tc(tc_hi), .wrap(wrap_hi), .err(err_hi));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int wraps_hi, wraps_lo, rolls;
  logic [15:0] prev, cur;

  initial begin
    tie0 = 1'b0; tie_val = 8'h00; cen = 1'b0;
    rst = 1'b0;
    en2 = 1'b1; up2 = 1'b1; clr2 = 1'b0; load2 = 1'b1; lv2 = 8'h55;
    en3 = 1'b1; up3 = 1'b1; clr3 = 1'b0; load3 = 1'b1; lv3 = 12'h555;
    tick(); tick();
    chk("reset_q2", q2, 8'h00);
    chk("reset_wrap2", wrap2, 1'b0);
    chk("reset_err2", err2, 1'b0);
    chk("reset_q3", q3, 12'h000);
    chk("reset_casc", {q_hi, q_lo}, 16'h0000);

    rst = 1'b1; load2 = 1'b0; load3 = 1'b0; en3 = 1'b0;
    tick();
    chk("count_after_reset", q2, 8'h01);

    // up-count wrap, two digits
    en2 = 1'b0; load2 = 1'b1; lv2 = 8'h97;
    tick();
    chk("load_97", q2, 8'h97);
    load2 = 1'b0; en2 = 1'b1; up2 = 1'b1;
    #1 chk("tc_at_97", tc2, 1'b0);
    tick();
    chk("up_98", q2, 8'h98);
    tick();
    chk("up_99", q2, 8'h99);
    chk("tc_at_99", tc2, 1'b1);
    chk("wrap_at_99", wrap2, 1'b0);
    tick();
`ifdef BCD_CNT_SATURATE_EN
    chk("up_sat", q2, 8'h99);
    chk("wrap_sat_up", wrap2, 1'b0);
`else
    chk("up_wrap_00", q2, 8'h00);
    chk("wrap_pulse_up", wrap2, 1'b1);
`endif
    en2 = 1'b0;
    tick();
    chk("wrap_one_cycle", wrap2, 1'b0);
`ifdef BCD_CNT_SATURATE_EN
    chk("idle_hold", q2, 8'h99);
`else
    chk("idle_hold", q2, 8'h00);
`endif

    // invalid digit load
    load2 = 1'b1; lv2 = 8'h3C; en2 = 1'b1;
    tick();
    chk("bad_load_q", q2, 8'h30);
    chk("bad_load_err", err2, 1'b1);
    load2 = 1'b0; clr2 = 1'b1;
    tick();
    chk("clr_q", q2, 8'h00);
    chk("clr_keeps_err", err2, 1'b1);
    clr2 = 1'b0; en2 = 1'b0;

    // down-count borrow, three digits
    load3 = 1'b1; lv3 = 12'h100;
    tick();
    chk("load_100", q3, 12'h100);
    load3 = 1'b0; en3 = 1'b1; up3 = 1'b0;
    tick();
    chk("down_099", q3, 12'h099);
    tick();
    chk("down_098", q3, 12'h098);
    en3 = 1'b0; load3 = 1'b1; lv3 = 12'h000;
    tick();
    chk("load_000", q3, 12'h000);
    load3 = 1'b0; en3 = 1'b1; up3 = 1'b0;
    #1 chk("tc_at_000", tc3, 1'b1);
    tick();
`ifdef BCD_CNT_SATURATE_EN
    chk("down_sat", q3, 12'h000);
    chk("wrap_sat_down", wrap3, 1'b0);
`else
    chk("down_wrap_999", q3, 12'h999);
    chk("wrap_pulse_down", wrap3, 1'b1);
`endif

    // priority: clr over load over en
    clr3 = 1'b1; load3 = 1'b1; lv3 = 12'h555; en3 = 1'b1; up3 = 1'b1;
    tick();
    chk("prio_clr", q3, 12'h000);
    clr3 = 1'b0;
    tick();
    chk("prio_load", q3, 12'h555);
    load3 = 1'b0; up3 = 1'b1;
    tick();
    chk("dir_up_556", q3, 12'h556);
    up3 = 1'b0;
    tick();
    chk("dir_down_555", q3, 12'h555);
    chk("no_wrap_mid", wrap3, 1'b0);
    en3 = 1'b0;

    // reset mid-operation clears sticky err
    rst = 1'b0; en3 = 1'b1;
    tick();
    chk("reset_err", err2, 1'b0);
    chk("reset_mid_count", q3, 12'h000);
    rst = 1'b1; en3 = 1'b0;

    // cascade of two 2-digit stages
    wraps_hi = 0; wraps_lo = 0; rolls = 0;
    prev = {q_hi, q_lo};
    cen = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      tick();
      cur = {q_hi, q_lo};
      if (wrap_hi) wraps_hi++;
      if (wrap_lo) wraps_lo++;
      if (prev == 16'h9999 && cur == 16'h0000) rolls++;
      prev = cur;
    end
    cen = 1'b0;
`ifdef BCD_CNT_SATURATE_EN
    chk("casc_final", {q_hi, q_lo}, 16'h9999);
    chk("casc_wrap_hi", wraps_hi, 0);
    chk("casc_wrap_lo", wraps_lo, 0);
`else
    chk("casc_final", {q_hi, q_lo}, 16'h0000);
    chk("casc_rolls", rolls, 1);
    chk("casc_wrap_hi", wraps_hi, 1);
    chk("casc_wrap_lo", wraps_lo, 100);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bcd_updown_counter.md
Name: bcd_updown_counter

Overview:
Synchronous, parametrised multi-digit BCD up/down counter. It is the next generation of the team's single-digit ripple BCD counter: all digits are clocked on one edge, with no ripple clocking and no reset-by-decode glitch. It supports count enable, direction, synchronous clear and parallel load, and provides a terminal-count output and a registered wrap flag for cascading. It is intended for event, timer and display-counting datapaths.

Parameters:
DIGITS, 4, number of BCD digits (1..8); the counter width is 4*DIGITS bits.

Ports:
clk  input  1  clock; all state updates on posedge clk
rst  input  1  synchronous reset, active-low; sampled on posedge clk
en  input  1  count enable; the counter steps one unit per clock while high
up  input  1  direction: 1 = increment, 0 = decrement
clr  input  1  synchronous clear of the count to zero
load  input  1  synchronous parallel load
load_val  input  4*DIGITS  BCD load value; digit i is bits [4i+3:4i]
q  output  4*DIGITS  current count; digit 0 is least significant
tc  output  1  combinational terminal count
wrap  output  1  registered one-cycle pulse, high in the cycle after a wrap
err  output  1  sticky flag: a load contained a non-BCD digit

Behaviour:
- Reset: if rst is 0 at posedge clk, then q=0, wrap=0 and err=0. Reset overrides all other inputs.
- Priority per cycle: rst, then clr, then load, then en. Only the highest-priority active operation takes effect.
- clr: q <= 0 and wrap <= 0. err is unchanged.
- load: each digit of load_val is checked independently.
  - A digit of 0..9 is loaded as given.
  - A digit of 10..15 is loaded as 0, and err <= 1.
  - wrap <= 0.
- err stays high until the next reset. clr does not clear err.
- Count up (en=1, up=1):
  - Digit 0 increments. Digit i increments only when every lower digit equals 9.
  - A digit at 9 that increments becomes 0.
  - From all-9 the count goes to all-0 and wrap <= 1.
- Count down (en=1, up=0):
  - Digit 0 decrements. Digit i decrements only when every lower digit equals 0.
  - A digit at 0 that decrements becomes 9.
  - From all-0 the count goes to all-9 and wrap <= 1.
- Idle (en=0 with no clr or load): q holds and wrap <= 0.
- wrap is high for exactly one cycle per wrap event. With back-to-back wraps (DIGITS=1, en held) it is high on each wrap cycle.
- tc = en & (up ? (q == all-9) : (q == all-0)).
  - Purely combinational; it is not gated by clr or load.
  - Used as the en input of the next cascaded counter.
- Latency: q reflects clr, load or a count step one clock after the edge that samples it.
- Direction change takes effect on the same edge it is sampled. There is no pipeline and no hysteresis.
- q never holds a non-BCD digit in any reachable state.
- A reset asserted in the middle of a count returns q to 0 on that edge, with no partial update.

Optional Feature:
Macro: BCD_CNT_SATURATE_EN
- Defined: the counter saturates instead of wrapping.
  - With up=1 at all-9, q holds at all-9.
  - With up=0 at all-0, q holds at all-0.
  - wrap is tied to 0.
  - tc behaviour is unchanged, so tc flags the saturation point.
- Undefined: wrap-around behaviour exactly as described under Behaviour.

Test Plan:
- Reset: drive rst=0 for 2 cycles with en=1 and load=1 -> q=0, wrap=0, err=0. Release rst -> counting starts on the next edge.
- Up-count wrap, DIGITS=2: load 8'h97, then en=1, up=1 for 3 clocks.
  - q goes 98, 99, 00.
  - tc=1 while q=99.
  - wrap=1 only in the cycle q=00.
  - With BCD_CNT_SATURATE_EN defined: q goes 98, 99, 99 and wrap stays 0.
- Down-count borrow, DIGITS=3: load 12'h100, then en=1, up=0 -> q goes 099, then 098. After loading 000 and one step down -> q=999 with wrap=1.
- Priority: in one cycle set clr=1, load=1 (load_val=12'h555) and en=1 -> q=000. Next cycle set load=1 and en=1 -> q=555.
- Invalid load, DIGITS=2: load 8'h3C -> q=30 and err=1. Then clr -> q=00 and err stays 1. Then reset -> err=0.
- Cascade: connect two DIGITS=2 instances, with the upper instance's en driven by the lower's tc. Count 10000 cycles up -> combined q wraps from 9999 to 0000 exactly once, and the upper wrap pulses once.
